// File: rtl/exe_stage.sv
// Execute stage: latches the decode bundle, drives the one-hot ALU from the
// registered operands, issues the data-SRAM request for loads and stores, and
// hands results to the memory stage under valid/allowin flow control.
//
// ALU one-hot encoding (alu_op bit -> operation):
//   0 add, 1 sub, 2 slt, 3 sltu, 4 and, 5 nor, 6 or, 7 xor,
//   8 sll, 9 srl, 10 sra, 11 lui (result = src2)
//
// Optional build macro EXE_ALIGN_CHECK_EN: flags misaligned half/word accesses
// on es_ale and suppresses their memory request.
module exe_stage #(
    parameter int unsigned ADDR_W = 32,
    parameter int unsigned DATA_W = 32
) (
    input  logic              clk,
    input  logic              resetn,
    input  logic              ds_to_es_valid,
    output logic              es_allowin,
    input  logic [11:0]       ds_alu_op,
    input  logic [DATA_W-1:0] ds_src1,
    input  logic [DATA_W-1:0] ds_src2,
    input  logic [31:0]       ds_pc,
    input  logic              ds_mem_re,
    input  logic              ds_mem_we,
    input  logic [1:0]        ds_mem_size,
    input  logic [DATA_W-1:0] ds_st_data,
    input  logic [4:0]        ds_dest,
    input  logic              ds_gr_we,
    input  logic              ms_allowin,
    output logic              es_to_ms_valid,
    output logic [DATA_W-1:0] es_result,
    output logic [31:0]       es_pc,
    output logic [4:0]        es_dest,
    output logic              es_gr_we,
    output logic              es_mem_re,
    output logic              data_sram_req,
    output logic              data_sram_wr,
    output logic [1:0]        data_sram_size,
    output logic [3:0]        data_sram_wstrb,
    output logic [ADDR_W-1:0] data_sram_addr,
    output logic [DATA_W-1:0] data_sram_wdata,
    input  logic              data_sram_addr_ok
`ifdef EXE_ALIGN_CHECK_EN
    ,
    output logic              es_ale
`endif
);

    localparam int unsigned SH_W = 5;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_REQ  = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t            state;
    state_t            state_nxt;

    logic              es_valid;
    logic [11:0]       es_alu_op;
    logic [DATA_W-1:0] es_src1;
    logic [DATA_W-1:0] es_src2;
    logic              es_mem_we;
    logic [1:0]        es_mem_size;
    logic [DATA_W-1:0] es_st_data;

    logic [DATA_W-1:0] alu_result;
    logic              mem_op;
    logic              es_ready_go;
    logic              handoff;
    logic              reenter;
    logic              misalign;
    logic [1:0]        addr_lo;
    logic [SH_W-1:0]   sh;

    assign mem_op  = es_mem_re | es_mem_we;
    assign addr_lo = alu_result[1:0];
    assign sh      = es_src2[SH_W-1:0];
    assign handoff = es_to_ms_valid & ms_allowin;

`ifdef EXE_ALIGN_CHECK_EN
    assign misalign = ((es_mem_size == 2'd1) & addr_lo[0]) | (es_mem_size[1] & (|addr_lo));
    assign es_ale   = es_valid & mem_op & misalign;
    // The incoming bundle's address is not yet computed, so a follow-on memory
    // op always passes through IDLE where its alignment is known.
    assign reenter  = 1'b0;
`else
    assign misalign = 1'b0;
    assign reenter  = ds_to_es_valid & (ds_mem_re | ds_mem_we);
`endif

    // Decode bundle register: loads on accept, holds while stalled
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            es_valid    <= 1'b0;
            es_alu_op   <= '0;
            es_src1     <= '0;
            es_src2     <= '0;
            es_pc       <= '0;
            es_mem_re   <= 1'b0;
            es_mem_we   <= 1'b0;
            es_mem_size <= '0;
            es_st_data  <= '0;
            es_dest     <= '0;
            es_gr_we    <= 1'b0;
        end else if (es_allowin) begin
            es_valid <= ds_to_es_valid;
            if (ds_to_es_valid) begin
                es_alu_op   <= ds_alu_op;
                es_src1     <= ds_src1;
                es_src2     <= ds_src2;
                es_pc       <= ds_pc;
                es_mem_re   <= ds_mem_re;
                es_mem_we   <= ds_mem_we;
                es_mem_size <= ds_mem_size;
                es_st_data  <= ds_st_data;
                es_dest     <= ds_dest;
                es_gr_we    <= ds_gr_we;
            end
        end
    end

    // One-hot ALU on registered operands
    always_comb begin
        alu_result = '0;
        if (es_alu_op[0])  alu_result = alu_result | (es_src1 + es_src2);
        if (es_alu_op[1])  alu_result = alu_result | (es_src1 - es_src2);
        if (es_alu_op[2])  alu_result = alu_result | DATA_W'($signed(es_src1) < $signed(es_src2));
        if (es_alu_op[3])  alu_result = alu_result | DATA_W'(es_src1 < es_src2);
        if (es_alu_op[4])  alu_result = alu_result | (es_src1 & es_src2);
        if (es_alu_op[5])  alu_result = alu_result | ~(es_src1 | es_src2);
        if (es_alu_op[6])  alu_result = alu_result | (es_src1 | es_src2);
        if (es_alu_op[7])  alu_result = alu_result | (es_src1 ^ es_src2);
        if (es_alu_op[8])  alu_result = alu_result | (es_src1 << sh);
        if (es_alu_op[9])  alu_result = alu_result | (es_src1 >> sh);
        if (es_alu_op[10]) alu_result = alu_result | DATA_W'($signed(es_src1) >>> sh);
        if (es_alu_op[11]) alu_result = alu_result | es_src2;
    end

    // Request FSM state register
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state <= S_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Request FSM next state
    always_comb begin
        state_nxt = state;
        case (state)
            S_IDLE: begin
                if (es_valid & mem_op & ~misalign) state_nxt = S_REQ;
            end
            S_REQ: begin
                if (data_sram_addr_ok) begin
                    if (handoff) state_nxt = reenter ? S_REQ : S_IDLE;
                    else         state_nxt = S_DONE;
                end
            end
            S_DONE: begin
                if (handoff) state_nxt = reenter ? S_REQ : S_IDLE;
            end
            default: state_nxt = S_IDLE;
        endcase
    end

    // Stage handshake and request outputs
    always_comb begin
        es_ready_go    = 1'b0;
        data_sram_req  = 1'b0;
        es_ready_go    = ~mem_op | misalign | (state == S_DONE) |
                         ((state == S_REQ) & data_sram_addr_ok);
        data_sram_req  = (state == S_REQ);
        es_to_ms_valid = es_valid & es_ready_go;
        es_allowin     = ~es_valid | (es_ready_go & ms_allowin);
    end

    // Store strobe and lane-replicated write data
    always_comb begin
        data_sram_wstrb = 4'b0000;
        data_sram_wdata = es_st_data;
        case (es_mem_size)
            2'd0: begin
                data_sram_wstrb = 4'b0001 << addr_lo;
                data_sram_wdata = {4{es_st_data[7:0]}};
            end
            2'd1: begin
                data_sram_wstrb = addr_lo[1] ? 4'b1100 : 4'b0011;
                data_sram_wdata = {2{es_st_data[15:0]}};
            end
            default: begin
                data_sram_wstrb = 4'b1111;
                data_sram_wdata = es_st_data;
            end
        endcase
        if (!es_mem_we) data_sram_wstrb = 4'b0000;
    end

    assign es_result      = alu_result;
    assign data_sram_wr   = es_mem_we;
    assign data_sram_size = es_mem_size;
    assign data_sram_addr = ADDR_W'(alu_result);

endmodule

// File: tb/tb_exe_stage.sv
// Bench for exe_stage: scoreboard of handoffs and SRAM requests against a
// behavioural model, directed scenarios followed by randomized traffic.
module tb_exe_stage;

    logic        clk = 1'b0;
    logic        resetn;
    logic        ds_to_es_valid;
    logic        es_allowin;
    logic [11:0] ds_alu_op;
    logic [31:0] ds_src1, ds_src2, ds_pc, ds_st_data;
    logic        ds_mem_re, ds_mem_we, ds_gr_we;
    logic [1:0]  ds_mem_size;
    logic [4:0]  ds_dest;
    logic        ms_allowin;
    logic        es_to_ms_valid;
    logic [31:0] es_result, es_pc;
    logic [4:0]  es_dest;
    logic        es_gr_we, es_mem_re;
    logic        data_sram_req, data_sram_wr;
    logic [1:0]  data_sram_size;
    logic [3:0]  data_sram_wstrb;
    logic [31:0] data_sram_addr, data_sram_wdata;
    logic        data_sram_addr_ok;
    logic        ale_act;
`ifdef EXE_ALIGN_CHECK_EN
    logic        es_ale;
    assign ale_act = es_ale;
`else
    assign ale_act = 1'b0;
`endif

    exe_stage dut (
        .clk(clk), .resetn(resetn),
        .ds_to_es_valid(ds_to_es_valid), .es_allowin(es_allowin),
        .ds_alu_op(ds_alu_op), .ds_src1(ds_src1), .ds_src2(ds_src2), .ds_pc(ds_pc),
        .ds_mem_re(ds_mem_re), .ds_mem_we(ds_mem_we), .ds_mem_size(ds_mem_size),
        .ds_st_data(ds_st_data), .ds_dest(ds_dest), .ds_gr_we(ds_gr_we),
        .ms_allowin(ms_allowin), .es_to_ms_valid(es_to_ms_valid),
        .es_result(es_result), .es_pc(es_pc), .es_dest(es_dest),
        .es_gr_we(es_gr_we), .es_mem_re(es_mem_re),
        .data_sram_req(data_sram_req), .data_sram_wr(data_sram_wr),
        .data_sram_size(data_sram_size), .data_sram_wstrb(data_sram_wstrb),
        .data_sram_addr(data_sram_addr), .data_sram_wdata(data_sram_wdata),
        .data_sram_addr_ok(data_sram_addr_ok)
`ifdef EXE_ALIGN_CHECK_EN
        , .es_ale(es_ale)
`endif
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] result;
        logic [4:0]  dest;
        logic        gr_we;
        logic        mem_re;
        logic        ale;
    } hand_t;

    typedef struct packed {
        logic        wr;
        logic [1:0]  size;
        logic [3:0]  wstrb;
        logic [31:0] addr;
        logic [31:0] wdata;
    } req_t;

    hand_t hq[$];
    req_t  rq[$];
    int    checks = 0;
    int    errors = 0;
    int    req_seen = 0;
    bit    mon_en = 1'b0;
    bit    rand_en = 1'b0;

    task automatic chk(input string name, input logic [95:0] act, input logic [95:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference ALU, by operation index
    function automatic logic [31:0] ref_alu(input int k, input logic [31:0] a, input logic [31:0] b);
        case (k)
            0:  return a + b;
            1:  return a - b;
            2:  return ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
            3:  return (a < b) ? 32'd1 : 32'd0;
            4:  return a & b;
            5:  return ~(a | b);
            6:  return a | b;
            7:  return a ^ b;
            8:  return a << b[4:0];
            9:  return a >> b[4:0];
            10: return 32'($signed(a) >>> b[4:0]);
            default: return b;
        endcase
    endfunction

    function automatic int nbytes(input logic [1:0] sz);
        return (sz == 2'd0) ? 1 : (sz == 2'd1) ? 2 : 4;
    endfunction

    function automatic logic ref_misalign(input logic [1:0] sz, input logic [31:0] addr);
`ifdef EXE_ALIGN_CHECK_EN
        return (addr % nbytes(sz)) != 0;
`else
        return 1'b0;
`endif
    endfunction

    // Expected request: strobe covers the naturally aligned n-byte lane group
    function automatic req_t ref_req(input logic we, input logic [1:0] sz,
                                     input logic [31:0] addr, input logic [31:0] sd);
        req_t r;
        int n = nbytes(sz);
        int base = int'(addr[1:0]) - (int'(addr[1:0]) % n);
        r.wr = we;
        r.size = sz;
        r.addr = addr;
        for (int i = 0; i < 4; i++) begin
            r.wstrb[i] = we && (i >= base) && (i < base + n);
            r.wdata[i*8 +: 8] = sd[(i % n)*8 +: 8];
        end
        return r;
    endfunction

    // Monitor: compares handoffs and accepted requests, checks request hold
    logic prev_pending = 1'b0;
    req_t prev_req, cur_req;
    hand_t cur_hand, exp_hand;
    req_t  exp_req;
    always begin
        @(negedge clk);
        #3;
        if (mon_en && resetn) begin
            cur_req = '{wr: data_sram_wr, size: data_sram_size, wstrb: data_sram_wstrb,
                        addr: data_sram_addr, wdata: data_sram_wdata};
            if (prev_pending) begin
                chk("req_held", 96'(data_sram_req), 96'(1'b1));
                if (data_sram_req) chk("req_stable", 96'(cur_req), 96'(prev_req));
            end
            if (data_sram_req && data_sram_addr_ok) begin
                req_seen++;
                if (rq.size() == 0) chk("unexpected_req", 96'(cur_req), 96'(0) - 96'(1));
                else begin
                    exp_req = rq.pop_front();
                    chk("req_fields", 96'(cur_req), 96'(exp_req));
                end
            end
            if (es_to_ms_valid && ms_allowin) begin
                cur_hand = '{pc: es_pc, result: es_result, dest: es_dest,
                             gr_we: es_gr_we, mem_re: es_mem_re, ale: ale_act};
                if (hq.size() == 0) chk("unexpected_handoff", 96'(cur_hand), 96'(0) - 96'(1));
                else begin
                    exp_hand = hq.pop_front();
                    chk("handoff", 96'(cur_hand), 96'(exp_hand));
                end
            end
            prev_pending = data_sram_req && !data_sram_addr_ok;
            prev_req = cur_req;
        end else begin
            prev_pending = 1'b0;
        end
    end

    task automatic tick();
        @(negedge clk);
        if (rand_en) begin
            ms_allowin = 1'($urandom);
            data_sram_addr_ok = 1'($urandom);
        end
    endtask

    task automatic send(input int k, input logic [31:0] s1, input logic [31:0] s2,
                        input logic re, input logic we, input logic [1:0] sz,
                        input logic [31:0] sd, input logic [4:0] dest, input logic gwe);
        int n = 0;
        logic [31:0] res;
        tick();
        ds_alu_op = 12'(1) << k;
        ds_src1 = s1; ds_src2 = s2; ds_pc = $urandom;
        ds_mem_re = re; ds_mem_we = we; ds_mem_size = sz;
        ds_st_data = sd; ds_dest = dest; ds_gr_we = gwe;
        ds_to_es_valid = 1'b1;
        #4;
        while (!es_allowin && n < 500) begin
            tick();
            #4;
            n++;
        end
        if (!es_allowin) begin
            chk("send_timeout", 96'(es_allowin), 96'(1'b1));
            ds_to_es_valid = 1'b0;
            return;
        end
        res = ref_alu(k, s1, s2);
        hq.push_back('{pc: ds_pc, result: res, dest: dest, gr_we: gwe, mem_re: re,
                       ale: (re | we) && ref_misalign(sz, res)});
        if ((re | we) && !ref_misalign(sz, res)) rq.push_back(ref_req(we, sz, res, sd));
        @(posedge clk);
        #1;
        ds_to_es_valid = 1'b0;
    endtask

    task automatic wait_req();
        int n = 0;
        tick(); #3;
        while (!data_sram_req && n < 20) begin tick(); #3; n++; end
        chk("wait_req", 96'(data_sram_req), 96'(1'b1));
    endtask

    int r0, k, nwait;
    logic [1:0] sz;
    logic we;

    initial begin
        resetn = 1'b0;
        ds_to_es_valid = 1'b0; ds_alu_op = '0; ds_src1 = '0; ds_src2 = '0; ds_pc = '0;
        ds_mem_re = 1'b0; ds_mem_we = 1'b0; ds_mem_size = '0; ds_st_data = '0;
        ds_dest = '0; ds_gr_we = 1'b0; ms_allowin = 1'b1; data_sram_addr_ok = 1'b0;
        #12;
        chk("rst_allowin", 96'(es_allowin), 96'(1'b1));
        chk("rst_to_ms_valid", 96'(es_to_ms_valid), 96'(1'b0));
        chk("rst_req", 96'(data_sram_req), 96'(1'b0));
        chk("rst_outputs", 96'({es_result, es_pc, data_sram_addr}), 96'(0));
        chk("rst_wstrb", 96'({data_sram_wstrb, es_dest, es_gr_we, es_mem_re}), 96'(0));
        @(negedge clk);
        resetn = 1'b1;
        mon_en = 1'b1;

        // add 5 + 7
        send(0, 32'd5, 32'd7, 1'b0, 1'b0, 2'd2, 32'd0, 5'd3, 1'b1);
        chk("add_valid", 96'(es_to_ms_valid), 96'(1'b1));
        chk("add_result", 96'(es_result), 96'(32'd12));
        chk("add_no_req", 96'(data_sram_req), 96'(1'b0));
        repeat (3) begin tick(); #3; chk("alu_no_req", 96'(data_sram_req), 96'(1'b0)); end

        // st.b to 0x1003 with addr_ok held low
        data_sram_addr_ok = 1'b0;
        send(0, 32'h1000, 32'd3, 1'b0, 1'b1, 2'd0, 32'hA5, 5'd0, 1'b0);
        wait_req();
        chk("stb_addr", 96'(data_sram_addr), 96'(32'h1003));
        chk("stb_wstrb", 96'(data_sram_wstrb), 96'(4'b1000));
        chk("stb_wdata", 96'(data_sram_wdata), 96'(32'hA5A5A5A5));
        repeat (3) begin
            tick(); #3;
            chk("stb_stall_allowin", 96'(es_allowin), 96'(1'b0));
        end
        tick(); data_sram_addr_ok = 1'b1;
        tick(); data_sram_addr_ok = 1'b0;
        repeat (2) tick();

        // ld.w with memory stage stalled
        ms_allowin = 1'b0;
        data_sram_addr_ok = 1'b1;
        r0 = req_seen;
        send(0, 32'h2000, 32'h10, 1'b1, 1'b0, 2'd2, 32'd0, 5'd7, 1'b1);
        nwait = 0;
        tick(); #3;
        while (!es_to_ms_valid && nwait < 20) begin tick(); #3; nwait++; end
        chk("ldw_ready", 96'(es_to_ms_valid), 96'(1'b1));
        repeat (2) begin
            tick(); #3;
            chk("ldw_hold_valid", 96'(es_to_ms_valid), 96'(1'b1));
            chk("ldw_no_dup_req", 96'(data_sram_req), 96'(1'b0));
        end
        tick(); ms_allowin = 1'b1;
        repeat (2) tick();
        chk("ldw_req_count", 96'(req_seen - r0), 96'(1));

        // back-to-back st.h then ld.w
        r0 = req_seen;
        send(0, 32'h2000, 32'h2, 1'b0, 1'b1, 2'd1, 32'h1234BEEF, 5'd0, 1'b0);
        send(0, 32'h3000, 32'h0, 1'b1, 1'b0, 2'd2, 32'd0, 5'd9, 1'b1);
        repeat (8) tick();
        chk("b2b_req_count", 96'(req_seen - r0), 96'(2));

        // reset during an outstanding request
        data_sram_addr_ok = 1'b0;
        send(0, 32'h4000, 32'h4, 1'b1, 1'b0, 2'd2, 32'd0, 5'd1, 1'b1);
        wait_req();
        mon_en = 1'b0;
        #2 resetn = 1'b0;
        #1;
        chk("rst_mid_req", 96'(data_sram_req), 96'(1'b0));
        chk("rst_mid_valid", 96'(es_to_ms_valid), 96'(1'b0));
        chk("rst_mid_allowin", 96'(es_allowin), 96'(1'b1));
        hq.delete();
        rq.delete();
        tick();
        resetn = 1'b1;
        repeat (2) begin
            #3;
            chk("post_rst_allowin", 96'(es_allowin), 96'(1'b1));
            chk("post_rst_idle", 96'(data_sram_req), 96'(1'b0));
            tick();
        end
        mon_en = 1'b1;

`ifdef EXE_ALIGN_CHECK_EN
        // misaligned ld.w is flagged and never requested
        data_sram_addr_ok = 1'b1;
        r0 = req_seen;
        send(0, 32'h1000, 32'h2, 1'b1, 1'b0, 2'd2, 32'd0, 5'd4, 1'b1);
        chk("ale_flag", 96'(ale_act), 96'(1'b1));
        chk("ale_valid", 96'(es_to_ms_valid), 96'(1'b1));
        repeat (3) tick();
        chk("ale_no_req", 96'(req_seen - r0), 96'(0));
`endif

        // randomized traffic under random backpressure and addr_ok
        rand_en = 1'b1;
        for (int i = 0; i < 300; i++) begin
            if ($urandom_range(0, 1) == 0) begin
                k = $urandom_range(0, 11);
                send(k, $urandom, $urandom, 1'b0, 1'b0, 2'($urandom), $urandom,
                     5'($urandom), 1'($urandom));
            end else begin
                we = 1'($urandom);
                sz = 2'($urandom);
                send(0, $urandom & 32'hFFFF_FFF0, 32'($urandom_range(0, 7)), !we, we, sz,
                     we ? 32'($urandom) : 32'd0, 5'($urandom), !we);
            end
            repeat ($urandom_range(0, 2)) tick();
        end
        rand_en = 1'b0;
        ms_allowin = 1'b1;
        data_sram_addr_ok = 1'b1;
        nwait = 0;
        while (hq.size() > 0 && nwait < 200) begin tick(); nwait++; end
        repeat (2) tick();
        chk("drain_handoffs", 96'(hq.size()), 96'(0));
        chk("drain_requests", 96'(rq.size()), 96'(0));

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/exe_stage.md
Name: exe_stage

Overview:
- Execute pipeline stage of the LoongArch in-order core. Sits between decode and memory stages and directly feeds the 12-bit one-hot ALU (alu_op, alu_src1, alu_src2 -> alu_result).
- Latches the decode bundle and drives the ALU from registered operands.
- Generates the data-SRAM request for loads and stores, and holds it under a req/addr_ok handshake.
- Passes result and writeback info to the memory stage under valid/allowin flow control.

Parameters:
- ADDR_W, 32, data address width
- DATA_W, 32, datapath width (only 32 supported)

Ports:
- clk  in  1  core clock
- resetn  in  1  asynchronous active-low reset
- ds_to_es_valid  in  1  decode bundle valid
- es_allowin  out  1  stage can accept a bundle this cycle
- ds_alu_op  in  12  one-hot ALU control
- ds_src1  in  32  ALU operand 1 (rj)
- ds_src2  in  32  ALU operand 2 (rk/imm)
- ds_pc  in  32  instruction PC
- ds_mem_re  in  1  load
- ds_mem_we  in  1  store
- ds_mem_size  in  2  0=byte, 1=half, 2=word
- ds_st_data  in  32  store data (rd)
- ds_dest  in  5  destination register
- ds_gr_we  in  1  register write enable
- ms_allowin  in  1  memory stage can accept
- es_to_ms_valid  out  1  bundle valid to memory stage
- es_result  out  32  ALU result (the address for memory ops)
- es_pc  out  32  registered PC
- es_dest  out  5  registered dest, for hazard/forward logic
- es_gr_we  out  1  registered write enable
- es_mem_re  out  1  registered load flag
- data_sram_req  out  1  memory request
- data_sram_wr  out  1  1=store
- data_sram_size  out  2  access size
- data_sram_wstrb  out  4  byte write strobes
- data_sram_addr  out  32  access address
- data_sram_wdata  out  32  replicated store data
- data_sram_addr_ok  in  1  request accepted

Behaviour:
- Reset (resetn low, async): es_valid=0, FSM=IDLE, all registered bundle fields=0. Every output is therefore 0, except es_allowin=1.
- Bundle latch: on posedge, when ds_to_es_valid & es_allowin, capture all ds_* fields and set es_valid=1.
  - If es_allowin & !ds_to_es_valid, clear es_valid.
  - Bundle fields do not change while es_valid & !es_allowin.
- ALU instance is purely combinational on registered operands. es_result is valid in the same cycle es_valid rises (1-cycle stage latency).
- mem_op = es_mem_re | es_mem_we.
- FSM (memory ops only):
  - IDLE: when es_valid & mem_op, go to REQ.
  - REQ: data_sram_req=1. Go to DONE on addr_ok.
  - DONE: hold until es_to_ms handoff, then IDLE. A newly latched bundle in the same edge re-enters REQ if it is a memory op.
  - A REQ->DONE edge with a same-cycle handoff goes directly to IDLE or REQ by the same rule.
- Request hold: while data_sram_req=1 and addr_ok=0, req/wr/size/wstrb/addr/wdata must stay stable.
- Request timing: req is asserted the cycle after the bundle is latched (FSM leaves IDLE). It is never asserted in IDLE or DONE.
- es_ready_go = !mem_op | (state==DONE) | (state==REQ & addr_ok).
- es_to_ms_valid = es_valid & es_ready_go.
- es_allowin = !es_valid | (es_ready_go & ms_allowin).
- Address: data_sram_addr = es_result. Low 2 bits are forwarded unchanged.
- Store strobes, with a = addr[1:0]:
  - byte: wstrb = 1<<a; wdata = {4{st[7:0]}}
  - half: wstrb = a[1] ? 4'b1100 : 4'b0011; wdata = {2{st[15:0]}}
  - word: wstrb = 4'b1111; wdata = st
  - loads: wstrb = 0
- Size 3 is reserved and treated as word.
- Backpressure: ms_allowin=0 with a completed request holds the stage in DONE. No duplicate request is issued.
- Reset mid-request: FSM and es_valid clear immediately. req drops asynchronously.

Optional Feature:
- Macro: EXE_ALIGN_CHECK_EN.
- Enabled: misalignment is half with addr[0]=1, or word with addr[1:0]!=0.
  - A misaligned memory op never leaves IDLE and never asserts req.
  - es_ready_go=1 for that op.
  - Extra output es_ale=1 (registered-bundle-derived) travels with es_to_ms_valid.
- Disabled: no es_ale port, no check. Misaligned addresses are issued as computed.

Test Plan:
- add, src1=5, src2=7, ms_allowin=1 -> es_to_ms_valid the cycle after latch, es_result=12, data_sram_req never asserted.
- st.b with src1=0x1000, src2=3, st_data=0xA5 -> req=1, addr=0x1003, wstrb=4'b1000, wdata=0xA5A5A5A5.
  - With addr_ok held low 3 cycles: all request fields stable; es_allowin=0 throughout.
- ld.w, addr_ok=1 in the first REQ cycle, ms_allowin=0 for 2 cycles -> single req pulse, FSM held in DONE, es_to_ms_valid=1 held, handoff when ms_allowin=1.
- Back-to-back st.h to addr 0x2002 then ld.w to 0x3000, addr_ok always 1 -> wstrb 4'b1100, then a load req with wstrb=0. Exactly one req per instruction.
- resetn pulsed low while in REQ -> req, es_to_ms_valid, es_valid=0 asynchronously. After release, es_allowin=1 and FSM=IDLE.
- EXE_ALIGN_CHECK_EN set, ld.w at 0x1002 -> no req, es_ale=1, es_to_ms_valid next cycle.
